// File: rtl/fp_pkg.sv
// Shared single-precision FP types and constants for the multiply/accumulate path.
//   fp32_t          packed {sign, exp[7:0], man[22:0]}
//   FP_EXP_BIAS     IEEE-754 single exponent bias
//   FP_EXP_INF      all-ones exponent (Inf/NaN encoding)
//   FP_POS_INF/NEG  canonical signed infinities used for saturation
//   fp_acc_state_t  accumulator FSM states
//   fp_sig()        24-bit significand with hidden bit; zero/denormal -> 0
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam int         FP_EXP_BIAS = 127;
  localparam logic [7:0] FP_EXP_INF  = 8'hFF;
  localparam fp32_t      FP_POS_INF  = 32'h7F80_0000;
  localparam fp32_t      FP_NEG_INF  = 32'hFF80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_OUT
  } fp_acc_state_t;

  // Denormals are flushed: exp==0 contributes no magnitude at all.
  function automatic logic [23:0] fp_sig(input fp32_t f);
    return (f.exp == 8'd0) ? 24'd0 : {1'b1, f.man};
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter.
//   din  24-bit value, MSB first
//   cnt  number of leading zeros (24 when din is zero)
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  cnt
);

  // Ascending scan: the last hit wins, i.e. the highest set bit.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++)
      if (din[i]) cnt = 5'(23 - i);
  end

endmodule

// File: rtl/fp_accumulator.sv
// Sequential FP32 group accumulator behind the FP multiplier.
// One product per handshake is added into a running sum through a 4-state
// pipeline walk (IDLE/ALIGN/ADD/NORM); the product flagged in_last closes the
// group and the sum plus item count are held in OUT until taken.
// Truncating arithmetic, no rounding, denormals flushed to +0.
//   clk, nreset           clock, async active-low reset
//   in_valid/in_ready     product handshake (in_ready = state IDLE)
//   in_data, in_last      product and group-close flag
//   out_valid/out_ready   result handshake (out_valid = state OUT)
//   out_data, out_count   registered group sum and saturating item count
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  fp_acc_state_t    state;
  fp32_t            acc, cap;
  logic             cap_last;
  logic [CNT_W-1:0] cnt;

  // ALIGN -> ADD
  logic [23:0] ma, mb;
  logic        sa, sb;
  logic [7:0]  wexp;
  logic        inf_hit, inf_sign;

  // ADD -> NORM
  logic [24:0] sum;
  logic        sum_sign;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);

  // ---------------- ALIGN ----------------
  logic [23:0] sig_a, sig_b, sig_small;
  logic        a_ge;
  logic [7:0]  ediff;
  logic [23:0] small_sh;

  always_comb begin
    sig_a     = fp_sig(acc);
    sig_b     = fp_sig(cap);
    a_ge      = (acc.exp >= cap.exp);
    ediff     = a_ge ? (acc.exp - cap.exp) : (cap.exp - acc.exp);
    sig_small = a_ge ? sig_b : sig_a;
    small_sh  = (ediff >= 8'd25) ? 24'd0 : (sig_small >> ediff);
  end

  // ---------------- ADD ----------------
  logic [24:0] add_sum;
  logic        add_sign;

  always_comb begin
    add_sum  = '0;
    add_sign = 1'b0;
    if (sa == sb) begin
      add_sum  = {1'b0, ma} + {1'b0, mb};
      add_sign = sa;
    end else if (ma > mb) begin
      add_sum  = {1'b0, ma - mb};
      add_sign = sa;
    end else if (mb > ma) begin
      add_sum  = {1'b0, mb - ma};
      add_sign = sb;
    end
    // exact cancellation falls through as +0
  end

  // ---------------- NORM ----------------
  logic [4:0] lz;
  fp32_t      norm;

  fp_lzc24 u_lzc (
    .din (sum[23:0]),
    .cnt (lz)
  );

  always_comb begin
    norm = '0;
    if (inf_hit) begin
      norm = {inf_sign, FP_EXP_INF, 23'd0};
    end else if (sum == '0) begin
      norm = '0;
    end else if (sum[24]) begin
      // carry out: one right shift, exponent may saturate into Inf
      if (wexp >= 8'd254) norm = sum_sign ? FP_NEG_INF : FP_POS_INF;
      else                norm = {sum_sign, wexp + 8'd1, sum[23:1]};
    end else if ({3'b0, lz} >= wexp) begin
      norm = '0;  // exponent would reach <= 0: flush
    end else begin
      norm = {sum_sign, wexp - {3'b0, lz}, 23'(sum[23:0] << lz)};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cap       <= '0;
      cap_last  <= 1'b0;
      cnt       <= '0;
      ma        <= '0;
      mb        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      wexp      <= '0;
      inf_hit   <= 1'b0;
      inf_sign  <= 1'b0;
      sum       <= '0;
      sum_sign  <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cap      <= in_data;
            cap_last <= in_last;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            state    <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          ma       <= a_ge ? sig_a : small_sh;
          mb       <= a_ge ? small_sh : sig_b;
          // zero/denormal operands are +0 regardless of their sign bit
          sa       <= acc.sign & (acc.exp != 8'd0);
          sb       <= cap.sign & (cap.exp != 8'd0);
          wexp     <= a_ge ? acc.exp : cap.exp;
          // an Inf accumulator is sticky; otherwise an Inf input takes over
          inf_hit  <= (acc.exp == FP_EXP_INF) || (cap.exp == FP_EXP_INF);
          inf_sign <= (acc.exp == FP_EXP_INF) ? acc.sign : cap.sign;
          state    <= ST_ADD;
        end
        ST_ADD: begin
          sum      <= add_sum;
          sum_sign <= add_sign;
          state    <= ST_NORM;
        end
        ST_NORM: begin
          acc <= norm;
          if (cap_last) begin
            out_data  <= norm;
            out_count <= cnt;
            state     <= ST_OUT;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  fp_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_acc = '0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued add on integer significands, then renormalise.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, ma, mb, d, s, mag;
    logic sg;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return {b[31], 8'hFF, 23'd0};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : int'(a[22:0]) + (1 << 23);
    mb = (eb == 0) ? 0 : int'(b[22:0]) + (1 << 23);
    if (ea >= eb) begin
      e = ea; d = ea - eb; mb = (d >= 25) ? 0 : (mb >> d);
    end else begin
      e = eb; d = eb - ea; ma = (d >= 25) ? 0 : (ma >> d);
    end
    s = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    if (s == 0) return 32'd0;
    sg  = (s < 0);
    mag = sg ? -s : s;
    while (mag >= (1 << 24)) begin mag = mag >> 1; e++; end
    while (mag <  (1 << 23)) begin mag = mag << 1; e--; end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0)   return 32'd0;
    return {sg, 8'(e), 23'(mag)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int k;
    k = int'($urandom_range(0, 19));
    if (k == 0) return {1'($urandom), 8'h00, 23'($urandom)};
    if (k == 1) return {1'($urandom), 8'hFF, 23'($urandom)};
    if (k == 2) return {1'($urandom), 8'($urandom_range(252, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
  endfunction

  // Entered and left at a falling edge; returns in the cycle after the handshake.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic grp_add(input logic [31:0] d, input logic l);
    send(d, l);
    m_acc = ref_add(m_acc, d);
    if (m_cnt < CMAX) m_cnt++;
  endtask

  // Called right after the closing handshake; checks latency, hold, result.
  task automatic grp_end(input string tag, input int hold);
    logic [31:0] snap;
    chk({tag, "_lat0"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_busy"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk); chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk({tag, "_lat3"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  out_data, m_acc);
    chk({tag, "_count"}, 32'(out_count), 32'(m_cnt));
    snap = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"},  out_data, snap);
      chk({tag, "_hold_rdy"},   {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_rdy"},   {31'd0, in_ready}, 32'd1);
    chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    m_acc = '0;
    m_cnt = 0;
  endtask

  initial begin
    int n;
    // inputs during reset must be ignored
    in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

    // 1 + 2 = 3; out_ready held high outside OUT must do nothing
    out_ready = 1'b1;
    grp_add(32'h3F80_0000, 1'b0);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    grp_add(32'h4000_0000, 1'b1);
    chk("t1_model", m_acc, 32'h4040_0000);
    grp_end("t1", 0);

    // 1.5 + -1.5 = +0
    grp_add(32'h3FC0_0000, 1'b0);
    grp_add(32'hBFC0_0000, 1'b1);
    grp_end("cancel", 0);

    // tiny addend drops out in alignment
    grp_add(32'h3F80_0000, 1'b0);
    grp_add(32'h3080_0000, 1'b1);
    grp_end("dropout", 0);

    // overflow to +Inf
    grp_add(32'h7F00_0000, 1'b0);
    grp_add(32'h7F00_0000, 1'b1);
    grp_end("ovf", 0);

    // -Inf sticks
    grp_add(32'hFF80_0000, 1'b0);
    grp_add(32'h3F80_0000, 1'b1);
    grp_end("inf", 0);

    // lone denormal counts but sums to +0
    grp_add(32'h0040_0000, 1'b1);
    grp_end("denorm", 0);

    // underflow: 2^-126 - 1.5*2^-126 flushes to +0
    grp_add(32'h0080_0000, 1'b0);
    grp_add(32'h80C0_0000, 1'b1);
    grp_end("unf", 0);

    // back-pressure in OUT
    grp_add(32'h4080_0000, 1'b0);
    grp_add(32'hC000_0000, 1'b1);
    grp_end("hold", 5);

    // reset mid-group discards partial state
    send(32'h3F80_0000, 1'b0);
    nreset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_data",  out_data, 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    m_acc = '0; m_cnt = 0;
    grp_add(32'h4000_0000, 1'b1);
    grp_end("midrst", 0);

    // counter saturation: 17 items into a 4-bit counter
    for (int i = 0; i < 17; i++) grp_add(32'h3F80_0000, (i == 16));
    chk("sat_model", 32'(m_cnt), 32'(CMAX));
    grp_end("sat", 0);

    // random groups
    for (int g = 0; g < 25; g++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) grp_add(rnd_fp(), (i == n - 1));
      grp_end("rnd", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
